// File: rtl/hamming_secded_pipe_if.sv
// Handshake bundle for hamming_secded_pipe: encode-side request and decode-side result.
interface hamming_secded_pipe_if #(
  parameter int DATA_W = 8
);
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p = p + 1;
    return p;
  endfunction

  localparam int P      = calc_p(DATA_W);
  localparam int CODE_W = DATA_W + P + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              inj_en;
  logic [CODE_W-1:0] inj_mask;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic [DATA_W-1:0] out_data;
  logic [P-1:0]      out_syndrome;
  logic [1:0]        out_err_type;

  modport master (
    output in_valid, in_data, inj_en, inj_mask, out_ready,
    input  in_ready, out_valid, out_code, out_data, out_syndrome, out_err_type
  );

  modport slave (
    input  in_valid, in_data, inj_en, inj_mask, out_ready,
    output in_ready, out_valid, out_code, out_data, out_syndrome, out_err_type
  );
endinterface

// File: rtl/hamming_secded_pipe.sv
// Two-stage SECDED Hamming pipe: encode (+ optional error injection), then decode/correct,
// with saturating corrected / uncorrectable result counters.
module hamming_secded_pipe #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_secded_pipe_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_corr,
  output logic [CNT_W-1:0]     cnt_uncorr
);
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p = p + 1;
    return p;
  endfunction

  localparam int P      = calc_p(DATA_W);
  localparam int CODE_W = DATA_W + P + 1;
  localparam int IDX_W  = $clog2(CODE_W);
  localparam int DIDX_W = $clog2(DATA_W);
  localparam int PIDX_W = $clog2(P);

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_SINGLE = 2'b01,
    ERR_DOUBLE = 2'b10,
    ERR_PARITY = 2'b11
  } err_t;

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic              s2_ready;
  logic              xfer;
  logic [CODE_W-1:0] enc_word;
  logic [P-1:0]      enc_syn;
  logic [P-1:0]      dec_syn;
  logic              dec_gp;
  logic [CODE_W-1:0] fixed_word;
  err_t              dec_type;
  logic [DATA_W-1:0] dec_data;

  // The syndrome of the data-only word is exactly the set of check bits that zeroes it.
  always_comb begin
    int j;
    enc_word = '0;
    enc_syn  = '0;
    j        = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        enc_word[IDX_W'(pos)] = bus.in_data[DIDX_W'(j)];
        j = j + 1;
      end
    end
    for (int pos = 1; pos < CODE_W; pos++)
      if (enc_word[IDX_W'(pos)]) enc_syn = enc_syn ^ P'(pos);
    for (int k = 0; k < P; k++)
      enc_word[IDX_W'(1 << k)] = enc_syn[PIDX_W'(k)];
    enc_word[0] = ^enc_word[CODE_W-1:1];
  end

  always_comb begin
    int j;
    dec_syn = '0;
    j       = 0;
    for (int pos = 1; pos < CODE_W; pos++)
      if (s1_code[IDX_W'(pos)]) dec_syn = dec_syn ^ P'(pos);
    dec_gp     = ^s1_code;
    fixed_word = s1_code;
    dec_type   = ERR_NONE;
    if (dec_syn == '0) begin
      dec_type = dec_gp ? ERR_PARITY : ERR_NONE;
    end else if (!dec_gp || int'(dec_syn) >= CODE_W) begin
      dec_type = ERR_DOUBLE;
    end else begin
      dec_type = ERR_SINGLE;
      fixed_word[IDX_W'(dec_syn)] = ~fixed_word[IDX_W'(dec_syn)];
    end
    dec_data = '0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        dec_data[DIDX_W'(j)] = fixed_word[IDX_W'(pos)];
        j = j + 1;
      end
    end
  end

  // in_ready looks through to out_ready so a full pipe can accept and drain in one cycle.
  assign s2_ready     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_ready;
  assign xfer         = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid)
        s1_code <= enc_word ^ (bus.inj_en ? bus.inj_mask : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid    <= 1'b0;
      bus.out_code     <= '0;
      bus.out_data     <= '0;
      bus.out_syndrome <= '0;
      bus.out_err_type <= 2'b00;
    end else if (s2_ready) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_code     <= s1_code;
        bus.out_data     <= dec_data;
        bus.out_syndrome <= dec_syn;
        bus.out_err_type <= dec_type;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (xfer) begin
      if ((bus.out_err_type == ERR_SINGLE || bus.out_err_type == ERR_PARITY) && cnt_corr != '1)
        cnt_corr <= cnt_corr + CNT_W'(1);
      if (bus.out_err_type == ERR_DOUBLE && cnt_uncorr != '1)
        cnt_uncorr <= cnt_uncorr + CNT_W'(1);
    end
  end
endmodule
